// File: rtl/spawn_sched_pkg.sv
// -----------------------------------------------------------------------------
// spawn_sched_pkg
// Shared types and constants for the enemy spawn scheduler.
//   state_e   : scheduler FSM states
//   NUM_SLOTS : number of enemy slots arbitrated round-robin
//   DEC_W     : width of the timer-period decrement sent to timer_cluster
//   WAVE_W    : width of the completed-wave counter
//   DROP_W    : width of the optional dropped-tick counter
//   slot_add  : slot index arithmetic modulo NUM_SLOTS
// -----------------------------------------------------------------------------
package spawn_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        OFFER     = 2'd2,
        PAUSE     = 2'd3
    } state_e;

    localparam int NUM_SLOTS = 3;
    localparam int DEC_W     = 31;
    localparam int WAVE_W    = 8;
    localparam int DROP_W    = 16;

    // (s + k) mod NUM_SLOTS, for slot indices that are already in range.
    function automatic logic [1:0] slot_add(input logic [1:0] s, input int unsigned k);
        logic [31:0] t;
        t = (32'(s) + k) % 32'(NUM_SLOTS);
        return t[1:0];
    endfunction

endpackage

// File: rtl/rr_slot_picker.sv
// -----------------------------------------------------------------------------
// rr_slot_picker
// Purely combinational round-robin slot selector. Scans the slots starting
// one past the most recent grant and returns the first one that is free.
// Ports:
//   slot_busy  in  NUM_SLOTS  occupied flags per slot
//   last_grant in  2          slot granted most recently
//   any_free   out 1          at least one slot is free
//   pick       out 2          first free slot in round-robin order
// -----------------------------------------------------------------------------
module rr_slot_picker
    import spawn_sched_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] slot_busy,
    input  logic [1:0]           last_grant,
    output logic                 any_free,
    output logic [1:0]           pick
);

    // cand[k] is the (k+1)-th slot after last_grant; priority follows k.
    logic [1:0]           cand [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] cand_free;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cand
            assign cand[gi]      = slot_add(last_grant, gi + 1);
            assign cand_free[gi] = !slot_busy[cand[gi]];
        end
    endgenerate

    always_comb begin
        any_free = |cand_free;
        if (cand_free[0]) begin
            pick = cand[0];
        end else if (cand_free[1]) begin
            pick = cand[1];
        end else begin
            pick = cand[2];
        end
    end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// enemy_spawn_scheduler
// Turns the timer cluster's random-address tick into spawn offers for the
// enemy slots. Each accepted tick is granted round-robin to a free slot and
// presented on a valid/ready handshake. Spawns are grouped into waves of
// WAVE_SIZE; after each wave the timer decrement `dec` grows by DEC_STEP
// (saturating at DEC_MAX) and PAUSE_TICKS ticks are swallowed.
//
// Optional feature macro: SPAWN_DROP_CNT_EN
//   When defined, adds drop_cnt, a saturating count of ticks dropped in
//   WAIT_TICK (all slots busy) or OFFER. Cleared on reset and on start.
//
// Ports:
//   clk          in   1            clock
//   rst          in   1            asynchronous, active-low reset
//   start        in   1            game-start pulse
//   stop         in   1            game-stop pulse (wins over start)
//   tick         in   1            spawn tick
//   tick_adr     in   ADRESSWIDTH  start address, valid with tick
//   slot_done    in   3            per-slot release pulses
//   spawn_ready  in   1            enemy datapath accepts the offer
//   spawn_valid  out  1            offer valid
//   spawn_slot   out  2            granted slot
//   spawn_adr    out  ADRESSWIDTH  start address of the offer
//   slot_busy    out  3            slot occupied flags
//   dec          out  31           timer period decrement
//   wave_num     out  8            completed waves, saturating
//   running      out  1            scheduler not idle
//   drop_cnt     out  16           dropped ticks (SPAWN_DROP_CNT_EN only)
// -----------------------------------------------------------------------------
module enemy_spawn_scheduler
    import spawn_sched_pkg::*;
#(
    parameter int ADRESSWIDTH = 8,
    parameter int WAVE_SIZE   = 8,
    parameter int DEC_STEP    = 10_000,
    parameter int DEC_MAX     = 60_000_000,
    parameter int PAUSE_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   tick,
    input  logic [ADRESSWIDTH-1:0] tick_adr,
    input  logic [NUM_SLOTS-1:0]   slot_done,
    input  logic                   spawn_ready,
    output logic                   spawn_valid,
    output logic [1:0]             spawn_slot,
    output logic [ADRESSWIDTH-1:0] spawn_adr,
    output logic [NUM_SLOTS-1:0]   slot_busy,
    output logic [DEC_W-1:0]       dec,
    output logic [WAVE_W-1:0]      wave_num,
    output logic                   running
`ifdef SPAWN_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]      drop_cnt
`endif
);

    localparam int WC_W = $clog2(WAVE_SIZE + 1);
    localparam int PC_W = $clog2(PAUSE_TICKS + 1);

    localparam logic [WC_W-1:0]  WAVE_LAST  = WC_W'(WAVE_SIZE - 1);
    localparam logic [PC_W-1:0]  PAUSE_LAST = PC_W'(PAUSE_TICKS - 1);
    localparam logic [DEC_W-1:0] DEC_MAX_V  = DEC_W'(DEC_MAX);
    localparam logic [DEC_W-1:0] DEC_STEP_V = DEC_W'(DEC_STEP);
    // Above this value one more step would overshoot the ceiling.
    localparam logic [DEC_W-1:0] DEC_LIM_V  = DEC_W'(DEC_MAX - DEC_STEP);

    state_e                 state_q, state_d;
    logic [1:0]             slot_q, slot_d;
    logic [ADRESSWIDTH-1:0] adr_q, adr_d;
    logic [1:0]             last_grant_q, last_grant_d;
    logic [NUM_SLOTS-1:0]   slot_busy_q, slot_busy_d;
    logic [DEC_W-1:0]       dec_q, dec_d;
    logic [WAVE_W-1:0]      wave_num_q, wave_num_d;
    logic [WC_W-1:0]        wave_cnt_q, wave_cnt_d;
    logic [PC_W-1:0]        pause_cnt_q, pause_cnt_d;
    logic                   spawn_valid_q, spawn_valid_d;
    logic                   running_q, running_d;

    logic                   accept;
    logic                   clear_busy;
    logic                   any_free;
    logic [1:0]             pick;

    rr_slot_picker u_picker (
        .slot_busy  (slot_busy_q),
        .last_grant (last_grant_q),
        .any_free   (any_free),
        .pick       (pick)
    );

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        adr_d        = adr_q;
        last_grant_d = last_grant_q;
        dec_d        = dec_q;
        wave_num_d   = wave_num_q;
        wave_cnt_d   = wave_cnt_q;
        pause_cnt_d  = pause_cnt_q;
        accept       = 1'b0;
        clear_busy   = 1'b0;

        if (state_q != IDLE && stop) begin
            // Stop overrides everything, including a same-cycle handshake.
            state_d     = IDLE;
            pause_cnt_d = '0;
            clear_busy  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_d     = WAIT_TICK;
                        dec_d       = '0;
                        wave_num_d  = '0;
                        wave_cnt_d  = '0;
                        pause_cnt_d = '0;
                        clear_busy  = 1'b1;
                    end
                end
                WAIT_TICK: begin
                    if (tick && any_free) begin
                        slot_d  = pick;
                        adr_d   = tick_adr;
                        state_d = OFFER;
                    end
                end
                OFFER: begin
                    if (spawn_ready) begin
                        accept       = 1'b1;
                        last_grant_d = slot_q;
                        if (wave_cnt_q == WAVE_LAST) begin
                            wave_cnt_d = '0;
                            wave_num_d = (wave_num_q == '1) ? wave_num_q : wave_num_q + 1'b1;
                            dec_d      = (dec_q > DEC_LIM_V) ? DEC_MAX_V : dec_q + DEC_STEP_V;
                            state_d    = PAUSE;
                        end else begin
                            wave_cnt_d = wave_cnt_q + 1'b1;
                            state_d    = WAIT_TICK;
                        end
                    end
                end
                PAUSE: begin
                    if (tick) begin
                        if (pause_cnt_q == PAUSE_LAST) begin
                            pause_cnt_d = '0;
                            state_d     = WAIT_TICK;
                        end else begin
                            pause_cnt_d = pause_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        spawn_valid_d = (state_d == OFFER);
        running_d     = (state_d != IDLE);
    end

    // Per-slot occupancy: a grant in the same cycle as slot_done keeps the
    // slot busy, since the new enemy is the one that now owns it.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_busy
            assign slot_busy_d[gi] = clear_busy                     ? 1'b0 :
                                     (accept && slot_q == 2'(gi))   ? 1'b1 :
                                     slot_done[gi]                  ? 1'b0 :
                                                                      slot_busy_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            adr_q         <= '0;
            last_grant_q  <= 2'd2;
            slot_busy_q   <= '0;
            dec_q         <= '0;
            wave_num_q    <= '0;
            wave_cnt_q    <= '0;
            pause_cnt_q   <= '0;
            spawn_valid_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            adr_q         <= adr_d;
            last_grant_q  <= last_grant_d;
            slot_busy_q   <= slot_busy_d;
            dec_q         <= dec_d;
            wave_num_q    <= wave_num_d;
            wave_cnt_q    <= wave_cnt_d;
            pause_cnt_q   <= pause_cnt_d;
            spawn_valid_q <= spawn_valid_d;
            running_q     <= running_d;
        end
    end

`ifdef SPAWN_DROP_CNT_EN
    logic              drop_event;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // Ticks lost for lack of a slot or because an offer is pending; ticks
    // swallowed by the inter-wave pause are intentional and not counted.
    assign drop_event = tick && !stop &&
                        ((state_q == WAIT_TICK && !any_free) || state_q == OFFER);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (state_q == IDLE && start && !stop) begin
            drop_cnt_d = '0;
        end else if (drop_event && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign spawn_valid = spawn_valid_q;
    assign spawn_slot  = slot_q;
    assign spawn_adr   = adr_q;
    assign slot_busy   = slot_busy_q;
    assign dec         = dec_q;
    assign wave_num    = wave_num_q;
    assign running     = running_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_enemy_spawn_scheduler
// Directed bench for enemy_spawn_scheduler with small wave parameters
// (WAVE_SIZE=2, DEC_STEP=10, DEC_MAX=25, PAUSE_TICKS=4). Each tick expected
// to spawn pushes {slot, adr, cycle of valid rise} into a queue; a monitor
// pops one entry per rising spawn_valid and checks that the offer stays
// stable while it is pending. Register-style outputs are checked directly.
// -----------------------------------------------------------------------------
module tb_enemy_spawn_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        tick;
    logic [7:0]  tick_adr;
    logic [2:0]  slot_done;
    logic        spawn_ready;
    logic        spawn_valid;
    logic [1:0]  spawn_slot;
    logic [7:0]  spawn_adr;
    logic [2:0]  slot_busy;
    logic [30:0] dec;
    logic [7:0]  wave_num;
    logic        running;
`ifdef SPAWN_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    enemy_spawn_scheduler #(
        .ADRESSWIDTH (8),
        .WAVE_SIZE   (2),
        .DEC_STEP    (10),
        .DEC_MAX     (25),
        .PAUSE_TICKS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .tick        (tick),
        .tick_adr    (tick_adr),
        .slot_done   (slot_done),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_adr   (spawn_adr),
        .slot_busy   (slot_busy),
        .dec         (dec),
        .wave_num    (wave_num),
        .running     (running)
`ifdef SPAWN_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    typedef struct {
        logic [1:0] slot;
        logic [7:0] adr;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Monitor: one scoreboard pop per new offer, stability while held.
    initial begin
        logic       prev_valid;
        logic [1:0] hold_slot;
        logic [7:0] hold_adr;
        exp_t       e;
        prev_valid = 1'b0;
        hold_slot  = '0;
        hold_adr   = '0;
        forever begin
            @(negedge clk);
            if (spawn_valid && !prev_valid) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_offer actual slot=%0d adr=%h cyc=%0d required none",
                             spawn_slot, spawn_adr, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (spawn_slot !== e.slot || spawn_adr !== e.adr || cyc != e.cyc) begin
                        miscompares++;
                        $display("FAIL offer actual slot=%0d adr=%h cyc=%0d required slot=%0d adr=%h cyc=%0d",
                                 spawn_slot, spawn_adr, cyc, e.slot, e.adr, e.cyc);
                    end else begin
                        $display("offer slot=%0d adr=%h cyc=%0d ok", spawn_slot, spawn_adr, cyc);
                    end
                end
                hold_slot = spawn_slot;
                hold_adr  = spawn_adr;
            end else if (spawn_valid && prev_valid) begin
                vectors++;
                if (spawn_slot !== hold_slot || spawn_adr !== hold_adr) begin
                    miscompares++;
                    $display("FAIL offer_hold actual slot=%0d adr=%h required slot=%0d adr=%h",
                             spawn_slot, spawn_adr, hold_slot, hold_adr);
                end
            end
            prev_valid = spawn_valid;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic [7:0] adr, input bit expect_spawn, input logic [1:0] exp_slot);
        if (expect_spawn) sb_q.push_back('{exp_slot, adr, cyc + 1});
        tick     = 1'b1;
        tick_adr = adr;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic pause_ticks();
        for (int i = 0; i < 4; i++) do_tick(8'hE0 + 8'(i), 1'b0, 2'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic pulse_done(input logic [2:0] m);
        slot_done = m;
        @(posedge clk);
        #1;
        slot_done = 3'b000;
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        tick        = 1'b0;
        tick_adr    = 8'h00;
        slot_done   = 3'b000;
        spawn_ready = 1'b1;

        // Reset state
        cyc_wait(3);
        chk("rst_valid",    32'(spawn_valid), 32'd0);
        chk("rst_running",  32'(running),     32'd0);
        chk("rst_busy",     32'(slot_busy),   32'd0);
        chk("rst_dec",      32'(dec),         32'd0);
        chk("rst_wave",     32'(wave_num),    32'd0);
        rst = 1'b1;
        cyc_wait(1);

        // Async reset in the middle of a pending offer
        pulse_start();
        chk("start_running", 32'(running), 32'd1);
        do_tick(8'hA0, 1'b1, 2'd0);
        cyc_wait(1);
        spawn_ready = 1'b0;
        do_tick(8'hA1, 1'b1, 2'd1);
        cyc_wait(2);
        chk("offer_pending", 32'(spawn_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid",   32'(spawn_valid), 32'd0);
        chk("arst_running", 32'(running),     32'd0);
        chk("arst_busy",    32'(slot_busy),   32'd0);
        chk("arst_slot",    32'(spawn_slot),  32'd0);
        chk("arst_adr",     32'(spawn_adr),   32'd0);
        cyc_wait(1);
        rst         = 1'b1;
        spawn_ready = 1'b1;
        cyc_wait(1);

        // Round-robin grants 0,1,2 with the first wave's pause in between
        pulse_start();
        do_tick(8'h11, 1'b1, 2'd0);
        cyc_wait(1);
        do_tick(8'h22, 1'b1, 2'd1);
        cyc_wait(1);
        chk("wave1_dec",  32'(dec),       32'd10);
        chk("wave1_num",  32'(wave_num),  32'd1);
        chk("wave1_busy", 32'(slot_busy), 32'b011);
        pause_ticks();
        do_tick(8'h33, 1'b1, 2'd2);
        cyc_wait(1);
        chk("all_busy", 32'(slot_busy), 32'b111);

        // All slots busy: tick dropped; freed slot 1 is granted next
        do_tick(8'h44, 1'b0, 2'd0);
        chk("drop_valid", 32'(spawn_valid), 32'd0);
`ifdef SPAWN_DROP_CNT_EN
        chk("drop_cnt1", 32'(drop_cnt), 32'd1);
`endif
        pulse_done(3'b010);
        chk("done1_busy", 32'(slot_busy), 32'b101);
        do_tick(8'h55, 1'b1, 2'd1);
        cyc_wait(1);
        chk("wave2_dec", 32'(dec),      32'd20);
        chk("wave2_num", 32'(wave_num), 32'd2);
        pause_ticks();
`ifdef SPAWN_DROP_CNT_EN
        chk("drop_cnt_pause", 32'(drop_cnt), 32'd1);
`endif

        // Back-pressure: offer held stable, ticks dropped; accept with a
        // same-cycle slot_done on the granted slot (grant keeps it busy)
        pulse_done(3'b001);
        spawn_ready = 1'b0;
        do_tick(8'h66, 1'b1, 2'd0);
        for (int i = 0; i < 5; i++) do_tick(8'h70 + 8'(i), 1'b0, 2'd0);
        chk("bp_valid", 32'(spawn_valid), 32'd1);
`ifdef SPAWN_DROP_CNT_EN
        chk("drop_cnt6", 32'(drop_cnt), 32'd6);
`endif
        spawn_ready = 1'b1;
        slot_done   = 3'b001;
        @(posedge clk);
        #1;
        slot_done = 3'b000;
        chk("accept_valid", 32'(spawn_valid), 32'd0);
        chk("set_wins_busy", 32'(slot_busy), 32'b111);
        cyc_wait(1);
        chk("single_accept", 32'(spawn_valid), 32'd0);

        // Dec saturation across further waves
        pulse_done(3'b100);
        do_tick(8'h88, 1'b1, 2'd2);
        cyc_wait(1);
        chk("wave3_dec", 32'(dec),      32'd25);
        chk("wave3_num", 32'(wave_num), 32'd3);
        pause_ticks();
        pulse_done(3'b001);
        do_tick(8'h99, 1'b1, 2'd0);
        cyc_wait(1);
        pulse_done(3'b010);
        do_tick(8'h9A, 1'b1, 2'd1);
        cyc_wait(1);
        chk("wave4_dec", 32'(dec),      32'd25);
        chk("wave4_num", 32'(wave_num), 32'd4);
        pause_ticks();
`ifdef SPAWN_DROP_CNT_EN
        chk("drop_cnt_end", 32'(drop_cnt), 32'd6);
`endif

        // Stop withdraws a pending offer; start+stop stays idle
        pulse_done(3'b100);
        spawn_ready = 1'b0;
        do_tick(8'hBB, 1'b1, 2'd2);
        chk("pre_stop_valid", 32'(spawn_valid), 32'd1);
        pulse_stop();
        chk("stop_valid",   32'(spawn_valid), 32'd0);
        chk("stop_busy",    32'(slot_busy),   32'd0);
        chk("stop_dec",     32'(dec),         32'd25);
        chk("stop_wave",    32'(wave_num),    32'd4);
        chk("stop_running", 32'(running),     32'd0);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_running", 32'(running), 32'd0);
        chk("ss_dec",     32'(dec),     32'd25);

        // Restart clears counters; last grant survives (was slot 1)
        spawn_ready = 1'b1;
        pulse_start();
        chk("restart_dec",  32'(dec),      32'd0);
        chk("restart_wave", 32'(wave_num), 32'd0);
`ifdef SPAWN_DROP_CNT_EN
        chk("restart_drop", 32'(drop_cnt), 32'd0);
`endif
        do_tick(8'hCC, 1'b1, 2'd2);
        cyc_wait(1);
        chk("restart_busy", 32'(slot_busy), 32'b100);
        pulse_stop();
        cyc_wait(2);

        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_offers actual=%0d pending required=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
